ifu_fetch: RTL
==============

// Module: ifu_fetch
// PURPOSE
// - Instruction fetch stage directly upstream of the decoder.
// - Owns the PC and issues 32-bit instruction reads to instruction memory over a valid/ready request channel.
// - Buffers returned instructions in a small in-order fetch queue and presents {pc, instr} to the ID stage with valid/ready.
// - Handles redirects (branch/jump from EX), discarding stale in-flight responses, and halt on ebreak.
// PARAMETERS
// - PC_RESET  64'h0000_0000_8000_0000  PC value loaded on reset.
// - FQ_DEPTH  2                        Fetch queue entries (power of 2, >=2); also the outstanding-request cap.
// PORTS
// - clk             in   1   Clock; all state updates on posedge.
// - rst             in   1   Synchronous, active-high reset.
// - imem_req_valid  out  1   Fetch request valid.
// - imem_req_ready  in   1   Memory accepts request this cycle.
// - imem_req_addr   out  64  Fetch address (= fetch PC, bits[1:0]=0).
// - imem_rsp_valid  in   1   Response valid; always accepted, in request order.
// - imem_rsp_data   in   32  Instruction word.
// - redirect_valid  in   1   Redirect PC (taken branch/jal/jalr), flush queue.
// - redirect_pc     in   64  New PC; bits[1:0] are forced to 0.
// - halt            in   1   ebreak seen in decode; stop fetching.
// - id_valid        out  1   Head of fetch queue valid.
// - id_ready        in   1   ID stage consumes head this cycle.
// - id_pc           out  64  PC of head instruction.
// - id_instr        out  32  Head instruction (ID zero-extends to 64).
// - halted          out  1   FSM in HALT.
// BEHAVIOUR
// - Reset: fetch_pc=PC_RESET, queue empty, outstanding=0, drop=0, state=RUN; imem_req_valid=0, id_valid=0, halted=0 in the cycle after rst.
// - FSM RUN/HALT:
//   - RUN->HALT when halt=1.
//   - HALT->RUN only on redirect_valid=1 with halt=0.
//   - Only rst otherwise leaves HALT.
//   - In HALT, imem_req_valid=0; queue still drains to ID; in-flight responses are still accepted.
// - Issue: imem_req_valid=1 iff RUN && !redirect_valid && (queue_count + outstanding) < FQ_DEPTH.
//   - Credit rule: queue never overflows.
//   - On req handshake: fetch_pc += 4 (modulo 2^64, wraps silently); outstanding++.
// - Response: outstanding-- on every imem_rsp_valid.
//   - drop>0: response discarded, drop--.
//   - drop=0: push {pc_tag, data}; pc_tag comes from a response-PC counter that tracks issue order.
// - Output: id_valid = queue non-empty; id_pc/id_instr = head, stable while id_valid && !id_ready.
//   - Pop on id_valid && id_ready.
//   - Push and pop in the same cycle are allowed, including at full and empty (bypass not required; latency req->ID >= 1 cycle after response).
// - Redirect (cycle N, highest priority):
//   - Queue cleared (any same-cycle pop or push is ignored).
//   - drop <= outstanding_after_N: requests outstanding at end of N, including a same-cycle response counted out.
//   - fetch_pc = response-PC counter = {redirect_pc[63:2], 2'b00}.
//   - No request issued in cycle N; fetch resumes from N+1.
//   - A response arriving in N is discarded.
// - Redirect + halt in the same cycle: PC updated, state -> HALT.
// - rst mid-transaction: all counters cleared.
//   - Late responses after reset are the memory side's responsibility (imem is reset concurrently).
// - id_pc/id_instr are 0 when queue empty (no X outputs).
// TESTING
// - Reset then id_ready=1, imem ready/1-cycle latency, data=i -> id_pc sequence 0x80000000, 0x80000004, 0x80000008 with matching instr; no bubbles after warm-up.
// - id_ready=0 for 10 cycles -> id_valid held, head stable, at most FQ_DEPTH requests issued, then imem_req_valid=0; release -> in-order drain.
// - 2 requests outstanding, redirect_valid to 0x80001003 -> both late responses dropped; next id_pc=0x80001000.
// - Redirect same cycle as id handshake and rsp_valid -> queue empty in N+1, rsp discarded, request addr in N+1 = redirect target.
// - halt=1 -> no new requests, queued entries still delivered, halted=1; redirect to 0x80000100 -> RUN, fetch resumes there.
// - fetch_pc=64'hFFFF_FFFF_FFFF_FFFC issued -> next addr 64'h0; rst asserted mid-stall -> next request at PC_RESET, id_valid=0.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem reads and
// buffers returned words in an in-order queue feeding the decoder.
module ifu_fetch #(
   parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
   parameter int unsigned FQ_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        halt,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [63:0] id_pc,
   output logic [31:0] id_instr,
   output logic        halted
);

   localparam int unsigned PtrW = $clog2(FQ_DEPTH);
   localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e          state_q, state_d;
   logic [63:0]     fetch_pc_q, fetch_pc_d;
   logic [63:0]     rsp_pc_q, rsp_pc_d;
   logic [CntW-1:0] count_q, count_d;
   logic [CntW-1:0] outstanding_q, outstanding_d;
   logic [CntW-1:0] drop_q, drop_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [63:0]     pc_mem    [FQ_DEPTH];
   logic [31:0]     instr_mem [FQ_DEPTH];

   logic [CntW:0]   inflight;
   logic [63:0]     redirect_tgt;
   logic            req_fire;
   logic            push;
   logic            pop;

   assign redirect_tgt = redirect_pc & ~64'h3;
   // Queued plus in-flight entries; bounding this by FQ_DEPTH keeps the queue from overflowing.
   assign inflight     = {1'b0, count_q} + {1'b0, outstanding_q};

   always_comb begin
      imem_req_valid = !rst && (state_q == StRun) && !redirect_valid
                       && (inflight < (CntW + 1)'(FQ_DEPTH));
      imem_req_addr  = fetch_pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      id_valid       = (count_q != '0);
      id_pc          = id_valid ? pc_mem[rd_ptr_q] : '0;
      id_instr       = id_valid ? instr_mem[rd_ptr_q] : '0;
      halted         = (state_q == StHalt);
      push           = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
      pop            = id_valid && id_ready && !redirect_valid;
   end

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      count_d       = count_q;
      drop_d        = drop_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid);

      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc_d = redirect_tgt;
         rsp_pc_d   = redirect_tgt;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         drop_d     = outstanding_d;
         state_d    = halt ? StHalt : StRun;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
         end
         if (imem_rsp_valid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CntW'(1);
            end else begin
               rsp_pc_d = rsp_pc_q + 64'd4;
            end
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         count_d = count_q + CntW'(push) - CntW'(pop);
         if (halt) begin
            state_d = StHalt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         fetch_pc_q    <= PC_RESET;
         rsp_pc_q      <= PC_RESET;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         pc_mem[wr_ptr_q]    <= rsp_pc_q;
         instr_mem[wr_ptr_q] <= imem_rsp_data;
      end
   end

endmodule
